// File: rtl/zmips_pkg.sv
// zmips_pkg -- shared zmips definitions.
//   MD_*        : muldiv op encodings (op[1] selects divide, op[0] selects signed)
//   md_state_t  : muldiv FSM state type
package zmips_pkg;

  localparam logic [1:0] MD_MULU = 2'b00;
  localparam logic [1:0] MD_MUL  = 2'b01;
  localparam logic [1:0] MD_DIVU = 2'b10;
  localparam logic [1:0] MD_DIV  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/zmips_n_adder.sv
// zmips_n_adder -- plain W-bit adder with carry-in.
//   i_a, i_b : addends
//   i_cin    : carry in (1 with an inverted i_b gives subtraction)
//   o_sum    : i_a + i_b + i_cin, modulo 2^W
module zmips_n_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum
);

  assign o_sum = i_a + i_b + {{(W-1){1'b0}}, i_cin};

endmodule

// File: rtl/zmips_muldiv.sv
// zmips_muldiv -- iterative multiply/divide unit for the zmips EX stage.
// Results land in a HI/LO pair (MIPS MULT/DIV convention). All state moves on
// the falling clock edge, like the zmips pipeline registers.
//   i_clk, i_rst_n  : clock (falling-edge), async active-low reset
//   i_start, i_op   : request + op (MD_MULU/MD_MUL/MD_DIVU/MD_DIV)
//   i_a, i_b        : multiplicand/dividend, multiplier/divisor
//   i_flush         : abort the operation in flight (CALC/SIGN)
//   o_busy          : high in CALC and SIGN; hazard unit stalls on it
//   o_done          : one-cycle pulse, o_hi/o_lo valid
//   o_hi, o_lo      : MUL: product halves; DIV: remainder / quotient
//   o_div_by_zero   : last divide had b == 0, held until the next accepted start
// Build option: define ZMIPS_MULDIV_DIV_EN to include the divide datapath.
// Without it, divide ops finish at once with hi = lo = 0 and no div_by_zero.
module zmips_muldiv
  import zmips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_flush,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo,
  output logic         o_div_by_zero
);

  localparam int CW = $clog2(W);

  md_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_acc;     // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]    r_mcand;   // multiplicand or divisor magnitude
  logic            r_neg_q;   // product / quotient sign
  logic [W-1:0]    r_hi, r_lo;
  logic            r_busy, r_done;
`ifdef ZMIPS_MULDIV_DIV_EN
  logic            r_is_div;
  logic            r_neg_r;   // remainder follows dividend sign
  logic            r_dbz;
`endif

  // Operand magnitudes for signed ops (most-negative maps to itself, which
  // is the correct unsigned magnitude).
  logic            w_a_neg, w_b_neg;
  logic [W-1:0]    w_a_mag, w_b_mag;
  assign w_a_neg = i_op[0] & i_a[W-1];
  assign w_b_neg = i_op[0] & i_b[W-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // Shared W+1-bit add/subtract step.
  logic [W:0]      w_add_a, w_add_b, w_sum;
  logic            w_add_cin;
  logic [2*W-1:0]  w_acc_step;

  always_comb begin
    // Multiply: add multiplicand to the upper half when the current
    // multiplier bit is set; the carry is kept in bit W.
    w_add_a   = {1'b0, r_acc[2*W-1:W]};
    w_add_b   = r_acc[0] ? {1'b0, r_mcand} : '0;
    w_add_cin = 1'b0;
`ifdef ZMIPS_MULDIV_DIV_EN
    if (r_is_div) begin
      // Divide: trial subtract of divisor from {remainder, next dividend bit}.
      w_add_a   = r_acc[2*W-1:W-1];
      w_add_b   = ~{1'b0, r_mcand};
      w_add_cin = 1'b1;
    end
`endif
  end

  zmips_n_adder #(.W(W+1)) u_add (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_cin (w_add_cin),
    .o_sum (w_sum)
  );

  always_comb begin
    w_acc_step = {w_sum, r_acc[W-1:1]};
`ifdef ZMIPS_MULDIV_DIV_EN
    if (r_is_div) begin
      // Sign bit clear means the subtract fit: keep the difference, quotient bit 1.
      if (!w_sum[W]) w_acc_step = {w_sum[W-1:0], r_acc[W-2:0], 1'b1};
      else           w_acc_step = {r_acc[2*W-2:0], 1'b0};
    end
`endif
  end

  // Sign fix-up applied in SIGN.
  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_res_hi, w_res_lo;

  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_res_hi = w_prod[2*W-1:W];
    w_res_lo = w_prod[W-1:0];
`ifdef ZMIPS_MULDIV_DIV_EN
    if (r_is_div) begin
      w_res_lo = r_neg_q ? -r_acc[W-1:0]   : r_acc[W-1:0];
      w_res_hi = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
    end
`endif
  end

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_neg_q  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef ZMIPS_MULDIV_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          if (i_start) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_cnt   <= CW'(W-1);
            if (!i_op[1]) begin
              r_acc    <= {{W{1'b0}}, w_b_mag};
              r_mcand  <= w_a_mag;
              r_state  <= CALC;
              r_busy   <= 1'b1;
`ifdef ZMIPS_MULDIV_DIV_EN
              r_is_div <= 1'b0;
              r_dbz    <= 1'b0;
`endif
            end else begin
`ifdef ZMIPS_MULDIV_DIV_EN
              r_is_div <= 1'b1;
              r_neg_r  <= w_a_neg;
              r_dbz    <= (i_b == '0);
              if (i_b == '0) begin
                // Divide by zero skips CALC: raw a in hi, all ones in lo.
                r_hi    <= i_a;
                r_lo    <= '1;
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_acc   <= {{W{1'b0}}, w_a_mag};
                r_mcand <= w_b_mag;
                r_state <= CALC;
                r_busy  <= 1'b1;
              end
`else
              r_hi    <= '0;
              r_lo    <= '0;
              r_state <= DONE;
              r_done  <= 1'b1;
`endif
            end
          end
        end
        CALC: begin
          if (i_flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc_step;
            if (r_cnt == '0) r_state <= SIGN;
            else             r_cnt   <= r_cnt - CW'(1);
          end
        end
        SIGN: begin
          r_busy <= 1'b0;
          if (i_flush) begin
            r_state <= IDLE;
          end else begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
`ifdef ZMIPS_MULDIV_DIV_EN
  assign o_div_by_zero = r_dbz;
`else
  assign o_div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_zmips_muldiv.sv
// Bench for zmips_muldiv (W = 32): table of directed vectors plus hand
// sequences for back-to-back, flush (CALC and SIGN) and async reset.
// Divide expectations follow ZMIPS_MULDIV_DIV_EN.
module tb_zmips_muldiv;
  import zmips_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zmips_muldiv #(.W(W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_op          (op),
    .i_a           (a),
    .i_b           (b),
    .i_flush       (flush),
    .o_busy        (busy),
    .o_done        (done),
    .o_hi          (hi),
    .o_lo          (lo),
    .o_div_by_zero (dbz)
  );

  typedef struct {
    string        nm;
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input string nm, input logic [1:0] o,
                              input logic [W-1:0] x, y, eh, el,
                              input logic ed, input int el_lat);
    vec_t v;
    v.nm = nm; v.op = o; v.a = x; v.b = y; v.hi = eh; v.lo = el;
    v.dbz = ed; v.lat = el_lat;
    vt.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called just after a posedge; the DUT samples on the following negedge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges after the accepting edge until done is seen.
  task automatic wait_done(output int lat, output logic saw_busy);
    lat = 0;
    saw_busy = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) saw_busy = 1'b1;
      @(negedge clk);
      lat++;
      @(posedge clk);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    @(posedge clk);
  endtask

  int           lat;
  logic         sb;
  logic         seen;
  logic [1:0]   fop;
  logic [W-1:0] f_hi, f_lo;

  initial begin
    add("mulu_max", MD_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, W+1);
    add("mul_m3x7", MD_MUL,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, W+1);
    add("mul_minsq", MD_MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, W+1);
    add("mulu_shift", MD_MULU, 32'h12345678, 32'h10,     32'h00000001, 32'h23456780, 1'b0, W+1);
    add("mul_5xm1", MD_MUL,  32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, W+1);
`ifdef ZMIPS_MULDIV_DIV_EN
    add("div_m7_2",  MD_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W+1);
    add("div_ovf",   MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, W+1);
    add("divu_100_7", MD_DIVU, 32'd100,     32'd7,        32'd2,        32'd14,       1'b0, W+1);
    add("div_7_m2",  MD_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, W+1);
    add("divu_max_1", MD_DIVU, 32'hFFFFFFFF, 32'd1,       32'd0,        32'hFFFFFFFF, 1'b0, W+1);
    add("divu_by0",  MD_DIVU, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 0);
`else
    add("div_off",   MD_DIV,  32'hFFFFFFF9, 32'd2,        32'd0,        32'd0,        1'b0, 0);
    add("divu_off",  MD_DIVU, 32'd100,      32'd0,        32'd0,        32'd0,        1'b0, 0);
`endif
    add("mulu_3x4",  MD_MULU, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0, W+1);

    // Reset state
    repeat (2) @(posedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);
    rst_n = 1'b1;
    cycle();

    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      wait_done(lat, sb);
      chk($sformatf("%s_lat", vt[i].nm), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("%s_busy", vt[i].nm), sb, (vt[i].lat != 0));
      chk($sformatf("%s_hi", vt[i].nm), hi, vt[i].hi);
      chk($sformatf("%s_lo", vt[i].nm), lo, vt[i].lo);
      chk($sformatf("%s_dbz", vt[i].nm), dbz, vt[i].dbz);
      cycle();
      chk($sformatf("%s_pulse", vt[i].nm), done, 0);
      chk($sformatf("%s_hold_lo", vt[i].nm), lo, vt[i].lo);
      chk($sformatf("%s_hold_dbz", vt[i].nm), dbz, vt[i].dbz);
    end

    // Back-to-back: start held while done is high is taken on that edge.
    issue(MD_MULU, 32'd2, 32'd3);
    wait_done(lat, sb);
    chk("b2b_first_lo", lo, 6);
    op = MD_MULU; a = 32'd4; b = 32'd5; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    chk("b2b_hold_lo", lo, 6);
    wait_done(lat, sb);
    chk("b2b_lat", 64'(lat), 64'(W+1));
    chk("b2b_lo", lo, 20);
    cycle();

    // Flush on the 10th CALC edge, with start also asserted on that edge.
    issue(MD_MULU, 32'd5, 32'd6);
    wait_done(lat, sb);
    chk("fl_pre_lo", lo, 30);
    cycle();
`ifdef ZMIPS_MULDIV_DIV_EN
    fop = MD_DIVU; f_hi = 32'd1; f_lo = 32'd7;
`else
    fop = MD_MULU; f_hi = 32'd0; f_lo = 32'd350;
`endif
    issue(fop, 32'd50, 32'd7);
    repeat (9) cycle();
    flush = 1'b1; start = 1'b1;
    cycle();
    flush = 1'b0; start = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_done", done, 0);
    chk("fl_hold_lo", lo, 30);
    chk("fl_hold_hi", hi, 0);
    seen = 1'b0;
    repeat (W+4) begin
      cycle();
      if (done === 1'b1) seen = 1'b1;
    end
    chk("fl_no_done", seen, 0);
    issue(fop, 32'd50, 32'd7);
    wait_done(lat, sb);
    chk("fl_again_lat", 64'(lat), 64'(W+1));
    chk("fl_again_lo", lo, f_lo);
    chk("fl_again_hi", hi, f_hi);
    cycle();

    // Flush while in SIGN (after W CALC edges).
    issue(MD_MULU, 32'd9, 32'd9);
    repeat (W) cycle();
    chk("fls_busy_pre", busy, 1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("fls_busy", busy, 0);
    chk("fls_done", done, 0);
    chk("fls_hold_lo", lo, f_lo);
    cycle();
    chk("fls_no_done", done, 0);

    // Async reset mid-CALC.
    issue(MD_MULU, 32'hFFFF, 32'hFFFF);
    repeat (5) cycle();
    chk("rstm_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_hi", hi, 0);
    chk("rstm_lo", lo, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_done", done, 0);
    chk("rstm_dbz", dbz, 0);
    @(posedge clk);
    rst_n = 1'b1;
    cycle();
    issue(MD_MULU, 32'd3, 32'd3);
    wait_done(lat, sb);
    chk("post_rst_lat", 64'(lat), 64'(W+1));
    chk("post_rst_lo", lo, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
